// File: rtl/gm_mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// Holds the tenure state encoding and the owner type.
package gm_mem_arb_pkg;

  localparam int GM_ADDR_W = 10;
  localparam int GM_DATA_W = 32;
  localparam int GM_BE_W   = GM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_OWN0 = OWN0;
  localparam logic [1:0] ST_OWN1 = OWN1;

  typedef logic owner_t;

  function automatic logic [1:0] own_state(input owner_t own);
    return own ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/gm_mem_arbiter_if.sv
// Avalon-MM requester bundle and single-port memory bundle used by gm_mem_arbiter.
// The arbiter takes the slave side of each requester and the master side of the memory.
interface gm_avmm_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) ();
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

interface gm_mem_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) ();
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/gm_mem_arbiter_rr_pick.sv
// Combinational winner selection for gm_mem_arbiter.
// Round-robin with burst tenure by default; GM_ARB_FIXED_PRI_EN makes m0 always win.
module gm_rr_pick
  import gm_mem_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
`ifndef GM_ARB_FIXED_PRI_EN
  input  logic [1:0]       state,
  input  logic [CNT_W-1:0] beat_cnt,
  input  owner_t           last_owner,
  output logic             restart,
`endif
  input  logic             req0,
  input  logic             req1,
  output logic             gnt_vld,
  output owner_t           gnt_own
);

`ifdef GM_ARB_FIXED_PRI_EN

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_own = ~req0 & req1;
  end

`else

  logic tenure_left;

  assign tenure_left = (beat_cnt < CNT_W'(BURST_MAX));

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_own = 1'b0;
    restart = 1'b0;
    case (state)
      ST_OWN0: begin
        if (req0 && tenure_left) begin
          gnt_own = 1'b0;
        end else if (req1) begin
          gnt_own = 1'b1;
        end else if (req0) begin
          // limit reached but nobody else wants the port: start a fresh tenure
          gnt_own = 1'b0;
          restart = 1'b1;
        end
      end
      ST_OWN1: begin
        if (req1 && tenure_left) begin
          gnt_own = 1'b1;
        end else if (req0) begin
          gnt_own = 1'b0;
        end else if (req1) begin
          gnt_own = 1'b1;
          restart = 1'b1;
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt_own = ~last_owner;
        end else begin
          gnt_own = req1;
        end
      end
    endcase
  end

`endif

endmodule

// File: rtl/gm_mem_arbiter.sv
// Shares one 1-cycle-latency memory port between two Avalon-MM requesters.
// Build option GM_ARB_FIXED_PRI_EN: fixed m0 priority, no tenure registers.
//
// state | meaning
// IDLE  | no beat accepted last cycle
// OWN0  | m0 holds the port, beat_cnt beats into its tenure
// OWN1  | m1 holds the port, beat_cnt beats into its tenure
module gm_mem_arbiter
  import gm_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = GM_ADDR_W,
  parameter int DATA_W    = GM_DATA_W,
  parameter int BE_W      = GM_BE_W,
  parameter int BURST_MAX = 4
) (
  input logic        clk,
  input logic        reset,
  gm_avmm_if.slave   m0,
  gm_avmm_if.slave   m1,
  gm_mem_if.master   mem
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic   req0;
  logic   req1;
  logic   pick_vld;
  owner_t gnt_own;
  logic   gnt_vld;
  logic   rd_acc;
  logic   rd_pend;
  owner_t rd_own;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_read;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef GM_ARB_FIXED_PRI_EN

  gm_rr_pick #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .req0    (req0),
    .req1    (req1),
    .gnt_vld (pick_vld),
    .gnt_own (gnt_own)
  );

`else

  logic [1:0]       state;
  logic [CNT_W-1:0] beat_cnt;
  owner_t           last_owner;
  logic             restart;
  logic             tenure_chg;

  gm_rr_pick #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .state      (state),
    .beat_cnt   (beat_cnt),
    .last_owner (last_owner),
    .restart    (restart),
    .req0       (req0),
    .req1       (req1),
    .gnt_vld    (pick_vld),
    .gnt_own    (gnt_own)
  );

  assign tenure_chg = (state != own_state(gnt_own));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      last_owner <= 1'b1;
    end else if (gnt_vld) begin
      state      <= own_state(gnt_own);
      last_owner <= gnt_own;
      if (tenure_chg || restart) begin
        beat_cnt <= CNT_W'(1);
      end else if (beat_cnt != CNT_W'(BURST_MAX)) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end else begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end
  end

`endif

  // reset overrides the grant combinationally so nothing reaches memory during reset
  assign gnt_vld = pick_vld & ~reset;

  always_comb begin
    sel_addr  = '0;
    sel_be    = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    sel_read  = 1'b0;
    if (gnt_vld) begin
      if (gnt_own) begin
        sel_addr  = m1.address;
        sel_be    = m1.byteenable;
        sel_wdata = m1.writedata;
        sel_write = m1.write;
        sel_read  = m1.read;
      end else begin
        sel_addr  = m0.address;
        sel_be    = m0.byteenable;
        sel_wdata = m0.writedata;
        sel_write = m0.write;
        sel_read  = m0.read;
      end
    end
  end

  assign mem.address    = sel_addr;
  assign mem.byteenable = sel_be;
  assign mem.writedata  = sel_wdata;
  assign mem.write      = sel_write;
  assign mem.chipselect = gnt_vld;
  assign mem.clken      = 1'b1;

  assign m0.waitrequest = ~(gnt_vld & ~gnt_own);
  assign m1.waitrequest = ~(gnt_vld & gnt_own);

  // a beat with both read and write set is a write
  assign rd_acc = gnt_vld & sel_read & ~sel_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_own  <= 1'b0;
    end else begin
      rd_pend <= rd_acc;
      rd_own  <= gnt_own;
    end
  end

  assign m0.readdata      = mem.readdata;
  assign m1.readdata      = mem.readdata;
  assign m0.readdatavalid = rd_pend & ~rd_own & ~reset;
  assign m1.readdatavalid = rd_pend & rd_own & ~reset;

endmodule

// File: tb/tb_gm_mem_arbiter.sv
// Self-checking bench for gm_mem_arbiter: per-cycle model compare plus directed literal checks.
module tb_gm_mem_arbiter;

  localparam int BMAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  always #5 clk = ~clk;

  gm_avmm_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) m0_if ();
  gm_avmm_if #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) m1_if ();
  gm_mem_if  #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) mem_if ();

  gm_mem_arbiter #(.BURST_MAX(BMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .mem   (mem_if)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memory stub: registered address, q valid the cycle after issue
  logic [31:0] mem_arr [1024];
  logic [31:0] mem_q;
  assign mem_if.readdata = mem_q;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= (i == 5) ? 32'hDEADBEEF : 32'h0;
    end else if (mem_if.chipselect) begin
      if (mem_if.write)
        for (int b = 0; b < 4; b++)
          if (mem_if.byteenable[b]) mem_arr[mem_if.address][8*b +: 8] <= mem_if.writedata[8*b +: 8];
      mem_q <= mem_arr[mem_if.address];
    end
  end

  // behavioural model: who owns the port follows from grant history
  logic [31:0] shadow [1024];
  int          m_last;
  int          m_run;
  bit          m_pend;
  int          m_pown;
  logic [31:0] m_pdata;

  function automatic int pick(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
`ifdef GM_ARB_FIXED_PRI_EN
    return r0 ? 0 : 1;
`else
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (m_run == 0) return 1 - m_last;
    if (m_run < BMAX) return m_last;
    return 1 - m_last;
`endif
  endfunction

  always @(negedge clk) begin
    bit r0, r1, w_rd, w_wr;
    int w;
    logic [9:0]  w_a;
    logic [3:0]  w_be;
    logic [31:0] w_d;
    if (preload) begin
      for (int i = 0; i < 1024; i++) shadow[i] = (i == 5) ? 32'hDEADBEEF : 32'h0;
    end
    r0 = m0_if.read | m0_if.write;
    r1 = m1_if.read | m1_if.write;
    w  = reset ? -1 : pick(r0, r1);
    w_rd = (w == 1) ? m1_if.read : m0_if.read;
    w_wr = (w == 1) ? m1_if.write : m0_if.write;
    w_a  = (w == 1) ? m1_if.address : m0_if.address;
    w_be = (w == 1) ? m1_if.byteenable : m0_if.byteenable;
    w_d  = (w == 1) ? m1_if.writedata : m0_if.writedata;

    chk("cyc_cs",    mem_if.chipselect, (w >= 0));
    chk("cyc_wait0", m0_if.waitrequest, (w != 0));
    chk("cyc_wait1", m1_if.waitrequest, (w != 1));
    chk("cyc_write", mem_if.write, (w >= 0) && w_wr);
    chk("cyc_clken", mem_if.clken, 1);
    chk("cyc_rdv0",  m0_if.readdatavalid, m_pend && m_pown == 0 && !reset);
    chk("cyc_rdv1",  m1_if.readdatavalid, m_pend && m_pown == 1 && !reset);
    if (w >= 0) begin
      chk("cyc_addr", mem_if.address, w_a);
      chk("cyc_be",   mem_if.byteenable, w_be);
      if (w_wr) chk("cyc_wdata", mem_if.writedata, w_d);
    end
    if (m_pend && !reset) begin
      if (m_pown == 0) chk("cyc_rdata0", m0_if.readdata, m_pdata);
      else             chk("cyc_rdata1", m1_if.readdata, m_pdata);
    end

    if (reset) begin
      m_last = 1;
      m_run  = 0;
      m_pend = 0;
      m_pown = 0;
    end else if (w < 0) begin
      m_run  = 0;
      m_pend = 0;
    end else begin
      if (m_run == 0 || w != m_last) m_run = 1;
      else m_run = (m_run == BMAX) ? 1 : m_run + 1;
      m_last  = w;
      m_pend  = w_rd && !w_wr;
      m_pown  = w;
      m_pdata = shadow[w_a];
      if (w_wr)
        for (int b = 0; b < 4; b++)
          if (w_be[b]) shadow[w_a][8*b +: 8] = w_d[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int n, input logic rd, input logic wr, input logic [9:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.byteenable = be; m0_if.writedata = wd;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.byteenable = be; m1_if.writedata = wd;
    end
  endtask

  task automatic idle(input int n);
    drv(n, 1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
  endtask

  function automatic logic [1:0] gnt_seen();
    return {~m1_if.waitrequest, ~m0_if.waitrequest};
  endfunction

  initial begin
    logic [1:0]  exp_c [9];
    logic [1:0]  exp_r [4];
    logic [9:0]  rd_a  [6];
    logic [31:0] rd_d  [6];
    int          pulses;

    exp_c = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`ifdef GM_ARB_FIXED_PRI_EN
    exp_r = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_r = '{2'b01, 2'b01, 2'b10, 2'b10};
`endif
    rd_a = '{10'h005, 10'h3FF, 10'h010, 10'h020, 10'h011, 10'h021};
    rd_d = '{32'hDEADBEEF, 32'h00005678, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h00000001, 32'h00000002};

    reset = 1'b1;
    preload = 1'b1;
    idle(0);
    idle(1);
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_wait0", m0_if.waitrequest, 1);
    chk("rst_wait1", m1_if.waitrequest, 1);
    chk("rst_cs", mem_if.chipselect, 0);
    chk("rst_rdv0", m0_if.readdatavalid, 0);

    // single read of preloaded word
    tick(); reset = 1'b0; drv(0, 1, 0, 10'h005, 4'hF, 32'h0);
    @(negedge clk); chk("t1_wait0", m0_if.waitrequest, 0);
    tick(); idle(0);
    @(negedge clk);
    chk("t1_rdv0", m0_if.readdatavalid, 1);
    chk("t1_rdata", m0_if.readdata, 32'hDEADBEEF);
    chk("t1_rdv1", m1_if.readdatavalid, 0);

    // continuous contention from a fresh reset
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    drv(0, 0, 1, 10'h010, 4'hF, 32'hA0A0A0A0);
    drv(1, 0, 1, 10'h020, 4'hF, 32'hB1B1B1B1);
`ifdef GM_ARB_FIXED_PRI_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("fp_gnt%0d", i), gnt_seen(), 2'b01);
    end
    tick(); idle(0);
    @(negedge clk); chk("fp_m1_after", gnt_seen(), 2'b10);
    tick(); idle(1);
`else
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt%0d", i), gnt_seen(), exp_c[i]);
    end
    tick(); idle(0); idle(1);
`endif
    @(negedge clk);

    // simultaneous request after idle, then let the loser finish
    tick();
    drv(0, 0, 1, 10'h011, 4'hF, 32'h00000001);
    drv(1, 0, 1, 10'h021, 4'hF, 32'h00000002);
    @(negedge clk);
`ifdef GM_ARB_FIXED_PRI_EN
    chk("alt_gnt", gnt_seen(), 2'b01);
    tick(); idle(0);
    @(negedge clk); chk("alt_loser", m1_if.waitrequest, 0);
`else
    chk("alt_gnt", gnt_seen(), 2'b10);
    tick(); idle(1);
    @(negedge clk); chk("alt_loser", m0_if.waitrequest, 0);
`endif
    tick(); idle(0); idle(1);

    // partial-byte write then read-back, back to back
    drv(1, 0, 1, 10'h3FF, 4'h3, 32'h12345678);
    @(negedge clk); chk("t3_wait1", m1_if.waitrequest, 0);
    tick(); idle(1); drv(0, 1, 0, 10'h3FF, 4'hF, 32'h0);
    @(negedge clk); chk("t3_wait0", m0_if.waitrequest, 0);
    tick(); idle(0);
    @(negedge clk);
    chk("t3_rdv0", m0_if.readdatavalid, 1);
    chk("t3_rdata", m0_if.readdata, 32'h00005678);

    // reset right after an accepted read swallows its valid
    tick(); drv(0, 1, 0, 10'h005, 4'hF, 32'h0);
    @(negedge clk); chk("t4_wait0", m0_if.waitrequest, 0);
    tick(); idle(0); drv(1, 1, 0, 10'h005, 4'hF, 32'h0); reset = 1'b1;
    @(negedge clk);
    chk("t4_rdv0", m0_if.readdatavalid, 0);
    chk("t4_wait1", m1_if.waitrequest, 1);
    chk("t4_cs", mem_if.chipselect, 0);
    tick(); reset = 1'b0; idle(1);
    @(negedge clk);
    chk("t4_rdv0_after", m0_if.readdatavalid, 0);
    chk("t4_rdv1_after", m1_if.readdatavalid, 0);

    // six back-to-back reads from m0
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); drv(0, 1, 0, rd_a[i], 4'hF, 32'h0);
      @(negedge clk);
      chk($sformatf("t5_wait%0d", i), m0_if.waitrequest, 0);
      if (m0_if.readdatavalid) pulses++;
      if (i > 0) chk($sformatf("t5_rdata%0d", i - 1), m0_if.readdata, rd_d[i - 1]);
    end
    tick(); idle(0);
    @(negedge clk);
    if (m0_if.readdatavalid) pulses++;
    chk("t5_rdata5", m0_if.readdata, rd_d[5]);
    tick();
    @(negedge clk);
    if (m0_if.readdatavalid) pulses++;
    chk("t5_pulses", pulses, 6);

    // read and write together is a write
    tick(); drv(1, 1, 1, 10'h030, 4'hF, 32'hCAFEF00D);
    @(negedge clk); chk("t6_write", mem_if.write, 1);
    tick(); idle(1);
    @(negedge clk); chk("t6_rdv1", m1_if.readdatavalid, 0);

    // m0 alone past the burst limit, then m1 joins mid-tenure
    for (int i = 0; i < 6; i++) begin
      tick(); drv(0, 0, 1, 10'h040 + 10'(i), 4'hF, 32'h100 + i);
      @(negedge clk); chk($sformatf("t7_solo%0d", i), m0_if.waitrequest, 0);
    end
    tick(); drv(1, 0, 1, 10'h050, 4'hF, 32'h55);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk($sformatf("t7_join%0d", i), gnt_seen(), exp_r[i]);
    end
    tick(); idle(0); idle(1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
